// File: rtl/tx_feed_fifo.sv
// Byte FIFO feeding the SPI transmit path: frame-aware go pulse,
// strobed {eop,valid,byte} words, overflow and starvation flags.
module tx_feed_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          wr_data,
    input  logic                wr_eop,
    input  logic                wr_en,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    output logic [DEPTH_LOG2:0] frames,
    input  logic                flush,
    output logic                go,
    output logic [15:0]         spi_data,
    output logic                spi_data_strobe,
    input  logic                spi_data_request,
    output logic                overflow,
    output logic                starved
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  in_frame;
    logic                  push;
    logic                  pop;
    logic                  go_nx;
    logic                  starve_nx;
    logic [8:0]            head;
    logic                  frm_push;
    logic                  frm_pop;

    assign full     = (level == FULL_LEVEL);
    assign push     = wr_en && !full;
    assign head     = mem[rd_ptr];
    assign frm_push = push && wr_eop;
    assign frm_pop  = pop && head[8];

    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        go_nx     = 1'b0;
        starve_nx = 1'b0;
        unique case (state)
            IDLE: begin
                pop       = spi_data_request && (level != '0);
                go_nx     = !in_frame && (frames != '0) && !spi_data_request;
                starve_nx = in_frame && spi_data_request && (level == '0);
                if (pop) state_nx = STROBE;
            end
            STROBE:  state_nx = GAP;
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Storage carries no reset; only entries behind the pointers are read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= {wr_eop, wr_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            frames          <= '0;
            in_frame        <= 1'b0;
            go              <= 1'b0;
            spi_data        <= '0;
            spi_data_strobe <= 1'b0;
            overflow        <= 1'b0;
            starved         <= 1'b0;
        end else if (flush) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            frames          <= '0;
            in_frame        <= 1'b0;
            go              <= 1'b0;
            spi_data_strobe <= 1'b0;
            overflow        <= 1'b0;
            starved         <= 1'b0;
        end else begin
            state           <= state_nx;
            go              <= go_nx;
            spi_data_strobe <= pop;
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                spi_data <= {head[8], 1'b1, 6'b0, head[7:0]};
            end
            if (wr_en && full) overflow <= 1'b1;
            if (starve_nx) starved <= 1'b1;
            // go and an eop pop are exclusive: go needs request low
            if (go_nx) in_frame <= 1'b1;
            else if (frm_pop) in_frame <= 1'b0;
            unique case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
            unique case ({frm_push, frm_pop})
                2'b10:   frames <= frames + (DEPTH_LOG2 + 1)'(1);
                2'b01:   frames <= frames - (DEPTH_LOG2 + 1)'(1);
                default: frames <= frames;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_feed_fifo.sv
// Bench for tx_feed_fifo: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_tx_feed_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_eop = 1'b0;
    logic        wr_en = 1'b0;
    logic        full;
    logic [4:0]  level;
    logic [4:0]  frames;
    logic        flush = 1'b0;
    logic        go;
    logic [15:0] spi_data;
    logic        spi_data_strobe;
    logic        spi_data_request = 1'b0;
    logic        overflow;
    logic        starved;

    tx_feed_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk),
        .reset(reset),
        .wr_data(wr_data),
        .wr_eop(wr_eop),
        .wr_en(wr_en),
        .full(full),
        .level(level),
        .frames(frames),
        .flush(flush),
        .go(go),
        .spi_data(spi_data),
        .spi_data_strobe(spi_data_strobe),
        .spi_data_request(spi_data_request),
        .overflow(overflow),
        .starved(starved)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    logic seen_ee = 1'b0;

    logic [8:0]  q[$];
    int          busy;
    logic        m_in, m_go, m_stb, m_ovf, m_st;
    logic [15:0] m_sd;

    typedef struct {
        logic        we;
        logic [7:0]  d;
        logic        e;
        logic        rq;
        logic [4:0]  lvl;
        logic [4:0]  frm;
        logic        g;
        logic        stb;
        logic [15:0] sd;
    } vec_t;
    vec_t tbl[14];

    function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endfunction

    function automatic int eop_count();
        int n = 0;
        foreach (q[i]) if (q[i][8]) n++;
        return n;
    endfunction

    function automatic void model_reset();
        q.delete();
        busy  = 0;
        m_in  = 1'b0;
        m_go  = 1'b0;
        m_stb = 1'b0;
        m_ovf = 1'b0;
        m_st  = 1'b0;
        m_sd  = '0;
    endfunction

    function automatic void model_update(logic we, logic [7:0] d, logic e,
                                         logic rq, logic fl);
        logic       idle;
        logic       dopop;
        logic       g;
        int         sz;
        logic [8:0] w;
        if (fl) begin
            q.delete();
            busy  = 0;
            m_in  = 1'b0;
            m_go  = 1'b0;
            m_stb = 1'b0;
            m_ovf = 1'b0;
            m_st  = 1'b0;
            return;
        end
        idle  = (busy == 0);
        sz    = q.size();
        dopop = idle && rq && sz > 0;
        g     = idle && !m_in && eop_count() != 0 && !rq;
        if (idle && m_in && rq && sz == 0) m_st = 1'b1;
        if (busy > 0) busy--;
        m_stb = 1'b0;
        if (dopop) begin
            w     = q.pop_front();
            m_sd  = {w[8], 1'b1, 6'b0, w[7:0]};
            m_stb = 1'b1;
            busy  = 2;
            if (w[8]) m_in = 1'b0;
        end
        m_go = g;
        if (g) m_in = 1'b1;
        if (we) begin
            if (sz == 16) m_ovf = 1'b1;
            else q.push_back({e, d});
        end
    endfunction

    task automatic step(input logic we, input logic [7:0] d, input logic e,
                        input logic rq, input logic fl);
        @(negedge clk);
        wr_en            = we;
        wr_data          = d;
        wr_eop           = e;
        spi_data_request = rq;
        flush            = fl;
        @(posedge clk);
        model_update(we, d, e, rq, fl);
        #1;
        chk("model", 64'({full, level, frames, go, spi_data,
                          spi_data_strobe, overflow, starved}),
                     64'({q.size() == 16, 5'(q.size()), 5'(eop_count()),
                          m_go, m_sd, m_stb, m_ovf, m_st}));
        if (spi_data_strobe) begin
            strobes++;
            if (spi_data[7:0] == 8'hEE) seen_ee = 1'b1;
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 5'd2, 5'd0, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 5'd3, 5'd1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 5'd1, 1'b1, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd3, 5'd1, 1'b0, 1'b0, 16'h0000};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 5'd1, 1'b0, 1'b1, 16'h4011};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 5'd1, 1'b0, 1'b0, 16'h4011};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd2, 5'd1, 1'b0, 1'b0, 16'h4011};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b1, 16'h4022};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 16'h4022};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 16'h4022};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 16'hC033};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'hC033};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 16'hC033};

        model_reset();
        #12;
        chk("reset", 64'({full, level, frames, go, spi_data,
                          spi_data_strobe, overflow, starved}), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Frame of three bytes, then drained at request-paced intervals
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].we, tbl[i].d, tbl[i].e, tbl[i].rq, 1'b0);
            chk("vec", 64'({level, frames, go, spi_data_strobe, spi_data}),
                       64'({tbl[i].lvl, tbl[i].frm, tbl[i].g, tbl[i].stb, tbl[i].sd}));
        end

        // Fill to full and attempt one more write
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 8'(8'h80 + i), (i == 15), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        chk("full", 64'({full, overflow, level}), 64'({1'b1, 1'b1, 5'd16}));
        strobes = 0;
        repeat (50) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("drain_cnt", 64'(strobes), 64'(16));
        chk("drain_lvl", 64'(level), 64'(0));
        chk("no_17th", 64'(seen_ee), 64'(0));

        // Open-ended byte with no frame started, then its eop
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("p55", 64'({starved, spi_data}), 64'({1'b0, 16'h4055}));
        step(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("p66", 64'({frames, spi_data}), 64'({5'd0, 16'hC066}));
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("go_next", 64'(go), 64'(1));

        // Simultaneous write and pop
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 5; i++)
            step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("lvl5", 64'({level, frames}), 64'({5'd5, 5'd1}));
        step(1'b1, 8'h06, 1'b0, 1'b1, 1'b0);
        chk("wp_eop", 64'({level, frames, spi_data}), 64'({5'd5, 5'd0, 16'hC001}));
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        chk("wp_noeop", 64'({level, frames, spi_data}), 64'({5'd5, 5'd1, 16'h4002}));

        // Flush while the strobe is high
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 8'(8'hA0 + i), (i == 4), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("pre_flush", 64'({spi_data_strobe, level}), 64'({1'b1, 5'd4}));
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("flush", 64'({level, frames, spi_data_strobe, spi_data}),
                     64'({5'd0, 5'd0, 1'b0, 16'h40A0}));
        strobes = 0;
        repeat (8) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("no_strobe", 64'(strobes), 64'(0));

        // Asynchronous reset in the middle of a frame
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        wr_en            = 1'b0;
        spi_data_request = 1'b0;
        reset            = 1'b0;
        #1;
        chk("async_rst", 64'({full, level, frames, go, spi_data,
                              spi_data_strobe, overflow, starved}), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_hold", 64'({level, spi_data, spi_data_strobe}), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("post_rst", 64'(spi_data), 64'(16'hC0C1));

        repeat (3000)
            step(1'($urandom), 8'($urandom), ($urandom % 4) == 0,
                 1'($urandom), ($urandom % 64) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
